riscv_fetch: RTL and testbench

Instruction fetch stage of the RV32 core. Holds the program counter and issues one word-aligned read at a time to the instruction cache. Places each returned word, with its PC and fault flags, in a one-entry output buffer that feeds the decode stage through a valid/accept handshake. Also applies branch/exception redirects and generates the decode squash pulse.

---
 rtl/riscv_fetch_pkg.sv | 24 ++
 rtl/riscv_fetch_buffer.sv | 32 +++
 rtl/riscv_fetch.sv | 124 ++++++++++++
 tb/tb_riscv_fetch.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_fetch_pkg.sv
// Shared core definitions for the RV32 fetch stage: reset vector, PC step,
// instruction width and the record carried by the fetch output buffer.
package riscv_fetch_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;

    localparam logic [XLEN-1:0] BOOT_VECTOR_DEFAULT = 32'h8000_0000;
    localparam logic [XLEN-1:0] PC_INC              = 32'd4;

    // One fetched word as presented to decode.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [XLEN-1:0]    pc;
        logic               fault_fetch;
        logic               fault_page;
    } fetch_entry_t;

    // Force an address onto a word boundary; the low two bits carry no meaning.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/riscv_fetch_buffer.sv
// One-entry output buffer between fetch and decode. A flush empties it, a
// load fills it, and a drain (decode accepting the word) empties it when no
// load happens in the same cycle.
module riscv_fetch_buffer
    import riscv_fetch_pkg::*;
(
    input  logic         InClk,
    input  logic         InRst,
    input  logic         load,
    input  fetch_entry_t load_entry,
    input  logic         drain,
    input  logic         flush,
    output logic         valid,
    output fetch_entry_t entry
);

    // Buffer occupancy and contents; flush wins, then load, then drain.
    always_ff @(posedge InClk or posedge InRst) begin
        if (InRst) begin
            valid <= 1'b0;
            entry <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            entry <= load_entry;
        end else if (drain && valid) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/riscv_fetch.sv
// RV32 instruction fetch stage. Keeps the PC, issues one word-aligned icache
// read at a time, parks each response in a one-entry buffer for decode, and
// applies branch/exception redirects (with a same-cycle decode squash).
//
// Handshakes: the icache request is taken in a cycle where OutIcacheRd and
// InIcacheAccept are both high, and OutIcacheRd/OutIcachePc hold until then
// unless a redirect intervenes. The icache response is a one-cycle pulse on
// InIcacheValid with no back-pressure; it only counts while a request is
// outstanding. Decode consumes the output word in a cycle where OutFetchValid
// and InFetchAccept are both high.
module riscv_fetch
    import riscv_fetch_pkg::*;
#(
    parameter logic [31:0] BOOT_VECTOR = BOOT_VECTOR_DEFAULT
)
(
    input  logic        InClk,
    input  logic        InRst,
    input  logic        InFetchAccept,
    input  logic        InBranchRequest,
    input  logic [31:0] InBranchPc,
    input  logic        InIcacheAccept,
    input  logic        InIcacheValid,
    input  logic [31:0] InIcacheInst,
    input  logic        InIcacheError,
    input  logic        InIcachePageFault,
    output logic        OutIcacheRd,
    output logic [31:0] OutIcachePc,
    output logic        OutFetchValid,
    output logic [31:0] OutFetchInstr,
    output logic [31:0] OutFetchPc,
    output logic        OutFetchFaultFetch,
    output logic        OutFetchFaultPage,
    output logic        OutSquashDecode
);

    logic [31:0]  pc_q;
    logic [31:0]  resp_pc_q;
    logic         active_q;
    logic         drop_q;
    logic         halt_q;

    logic         issue;
    logic         req_fire;
    logic         resp_fire;
    logic         resp_load;
    logic         resp_fault;
    logic         buf_valid;
    fetch_entry_t load_entry;
    fetch_entry_t buf_entry;

    // Only issue when nothing is in flight, we are not stalled on a fault, no
    // redirect is pending, and the buffer will be free when the response lands.
    assign issue      = !active_q && !halt_q && !InBranchRequest && (!buf_valid || InFetchAccept);
    assign req_fire   = OutIcacheRd && InIcacheAccept;
    assign resp_fire  = InIcacheValid && active_q;
    assign resp_load  = resp_fire && !drop_q && !InBranchRequest;
    assign resp_fault = InIcacheError || InIcachePageFault;

    assign load_entry.instr       = resp_fault ? '0 : InIcacheInst;
    assign load_entry.pc          = resp_pc_q;
    assign load_entry.fault_fetch = InIcacheError;
    assign load_entry.fault_page  = InIcachePageFault;

    // PC, outstanding-request tracking, drop-on-redirect and fault stall.
    always_ff @(posedge InClk or posedge InRst) begin
        if (InRst) begin
            pc_q      <= BOOT_VECTOR;
            resp_pc_q <= '0;
            active_q  <= 1'b0;
            drop_q    <= 1'b0;
            halt_q    <= 1'b0;
        end else begin
            if (InBranchRequest) begin
                pc_q <= align_word(InBranchPc);
            end else if (req_fire) begin
                pc_q <= pc_q + PC_INC;
            end

            if (req_fire) begin
                active_q  <= 1'b1;
                resp_pc_q <= pc_q;
            end else if (resp_fire) begin
                active_q <= 1'b0;
            end

            // A response arriving resolves any pending drop; otherwise a
            // redirect with a request in flight marks that response stale.
            if (resp_fire) begin
                drop_q <= 1'b0;
            end else if (InBranchRequest && active_q) begin
                drop_q <= 1'b1;
            end

            if (InBranchRequest) begin
                halt_q <= 1'b0;
            end else if (resp_load && resp_fault) begin
                halt_q <= 1'b1;
            end
        end
    end

    riscv_fetch_buffer u_buffer (
        .InClk      (InClk),
        .InRst      (InRst),
        .load       (resp_load),
        .load_entry (load_entry),
        .drain      (InFetchAccept),
        .flush      (InBranchRequest),
        .valid      (buf_valid),
        .entry      (buf_entry)
    );

    // While reset is held every output except the PC reads as zero.
    assign OutIcacheRd        = issue && !InRst;
    assign OutIcachePc        = pc_q;
    assign OutFetchValid      = buf_valid;
    assign OutFetchInstr      = buf_entry.instr;
    assign OutFetchPc         = buf_entry.pc;
    assign OutFetchFaultFetch = buf_entry.fault_fetch;
    assign OutFetchFaultPage  = buf_entry.fault_page;
    assign OutSquashDecode    = InBranchRequest && !InRst;

endmodule

// File: tb/tb_riscv_fetch.sv
// Bench for riscv_fetch: a behavioural icache with programmable latency,
// acceptance rate and fault addresses, directed scenario tasks, and a
// randomized run scored against a sequential-PC reference model.
`timescale 1ns/1ps
module tb_riscv_fetch;

    localparam logic [31:0] BOOT = 32'h8000_0000;

    logic        InClk;
    logic        InRst;
    logic        InFetchAccept;
    logic        InBranchRequest;
    logic [31:0] InBranchPc;
    logic        InIcacheAccept;
    logic        InIcacheValid;
    logic [31:0] InIcacheInst;
    logic        InIcacheError;
    logic        InIcachePageFault;
    logic        OutIcacheRd;
    logic [31:0] OutIcachePc;
    logic        OutFetchValid;
    logic [31:0] OutFetchInstr;
    logic [31:0] OutFetchPc;
    logic        OutFetchFaultFetch;
    logic        OutFetchFaultPage;
    logic        OutSquashDecode;

    int checks = 0;
    int errors = 0;

    // icache model configuration
    int          resp_lat      = 1;
    int          accept_pct    = 100;
    bit          hash_mode     = 0;
    logic [31:0] page_fault_pc = 32'h1;
    logic [31:0] err_fault_pc  = 32'h1;
    bit          stray_req     = 0;

    // icache model state
    bit          req_seen;
    logic [31:0] req_pc;
    int          req_lat;
    bit          pend_valid;
    logic [31:0] pend_pc;
    int          pend_cnt;

    // scoreboard for the randomized run
    logic [31:0] exp_q[$];

    riscv_fetch dut (
        .InClk              (InClk),
        .InRst              (InRst),
        .InFetchAccept      (InFetchAccept),
        .InBranchRequest    (InBranchRequest),
        .InBranchPc         (InBranchPc),
        .InIcacheAccept     (InIcacheAccept),
        .InIcacheValid      (InIcacheValid),
        .InIcacheInst       (InIcacheInst),
        .InIcacheError      (InIcacheError),
        .InIcachePageFault  (InIcachePageFault),
        .OutIcacheRd        (OutIcacheRd),
        .OutIcachePc        (OutIcachePc),
        .OutFetchValid      (OutFetchValid),
        .OutFetchInstr      (OutFetchInstr),
        .OutFetchPc         (OutFetchPc),
        .OutFetchFaultFetch (OutFetchFaultFetch),
        .OutFetchFaultPage  (OutFetchFaultPage),
        .OutSquashDecode    (OutSquashDecode)
    );

    // ---------------- clock ----------------
    initial begin
        InClk = 1'b0;
        forever #5 InClk = ~InClk;
    end

    // Program memory contents seen by the icache model.
    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        if (!hash_mode) return 32'h0000_0013;
        return {pc[15:0], pc[31:16]} ^ 32'hA5C3_0F17;
    endfunction

    // ---------------- icache model ----------------
    // Inputs change 1ns after the rising edge; requests are observed on the
    // falling edge and answered resp_lat cycles later.
    initial begin
        InIcacheAccept = 1'b0; InIcacheValid = 1'b0; InIcacheInst = '0;
        InIcacheError = 1'b0; InIcachePageFault = 1'b0;
        req_seen = 1'b0; req_pc = '0; req_lat = 1;
        pend_valid = 1'b0; pend_pc = '0; pend_cnt = 0;
        forever begin
            @(posedge InClk); #1;
            if (InRst) pend_valid = 1'b0;
            else if (req_seen) begin
                pend_valid = 1'b1; pend_pc = req_pc; pend_cnt = req_lat;
            end
            InIcacheValid = 1'b0; InIcacheInst = '0;
            InIcacheError = 1'b0; InIcachePageFault = 1'b0;
            if (stray_req) begin
                InIcacheValid = 1'b1; InIcacheInst = 32'hBAD0_0BAD; stray_req = 1'b0;
            end else if (pend_valid) begin
                if (pend_cnt <= 1) begin
                    InIcacheValid = 1'b1; pend_valid = 1'b0;
                    if (pend_pc == page_fault_pc) begin
                        InIcacheInst = 32'hDEAD_BEEF; InIcachePageFault = 1'b1;
                    end else if (pend_pc == err_fault_pc) begin
                        InIcacheInst = 32'hDEAD_BEEF; InIcacheError = 1'b1;
                    end else begin
                        InIcacheInst = mem_word(pend_pc);
                    end
                end else begin
                    pend_cnt = pend_cnt - 1;
                end
            end
            InIcacheAccept = ($urandom_range(0, 99) < accept_pct);
            @(negedge InClk);
            req_seen = InIcacheAccept && (OutIcacheRd === 1'b1);
            req_pc   = OutIcachePc;
            req_lat  = resp_lat;
        end
    end

    // ---------------- driver tasks ----------------
    // Hold reset two cycles, then release; returns 1ns into cycle 0.
    task automatic do_reset();
        @(posedge InClk); #1;
        InRst = 1'b1; InBranchRequest = 1'b0; InFetchAccept = 1'b1;
        @(posedge InClk);
        @(posedge InClk); #1;
        InRst = 1'b0;
    endtask

    task automatic test_reset();
        hash_mode = 0; resp_lat = 1; accept_pct = 100;
        page_fault_pc = 32'h1; err_fault_pc = 32'h1;
        @(posedge InClk); #1;
        InRst = 1'b1; InBranchRequest = 1'b0; InFetchAccept = 1'b1;
        @(negedge InClk);
        checks++; if (OutIcacheRd !== 1'b0) begin errors++; $display("FAIL reset_rd got %b exp 0", OutIcacheRd); end
        checks++; if (OutIcachePc !== BOOT) begin errors++; $display("FAIL reset_pc got %h exp %h", OutIcachePc, BOOT); end
        checks++;
        if ({OutFetchValid, OutFetchInstr, OutFetchPc, OutFetchFaultFetch, OutFetchFaultPage, OutSquashDecode} !== 68'h0) begin
            errors++; $display("FAIL reset_outs got v=%b i=%h pc=%h ff=%b fp=%b sq=%b exp all 0",
                OutFetchValid, OutFetchInstr, OutFetchPc, OutFetchFaultFetch, OutFetchFaultPage, OutSquashDecode);
        end
        @(posedge InClk); #1;
        InRst = 1'b0;
        @(negedge InClk);
        checks++;
        if ({OutIcacheRd, OutIcachePc} !== {1'b1, BOOT}) begin
            errors++; $display("FAIL reset_release got rd=%b pc=%h exp rd=1 pc=%h", OutIcacheRd, OutIcachePc, BOOT);
        end
    endtask

    task automatic test_stream();
        logic [31:0] e_req;
        logic [31:0] e_out;
        bit          even;
        hash_mode = 0; resp_lat = 1; accept_pct = 100;
        do_reset();
        @(negedge InClk);
        checks++; if ({OutIcacheRd, OutIcachePc} !== {1'b1, BOOT}) begin errors++; $display("FAIL stream_c0 got rd=%b pc=%h", OutIcacheRd, OutIcachePc); end
        for (int c = 1; c <= 8; c++) begin
            @(posedge InClk); #1;
            @(negedge InClk);
            even  = (c % 2 == 0);
            e_req = BOOT + 32'(4 * (c / 2));
            e_out = BOOT + 32'(4 * (c / 2 - 1));
            checks++;
            if ({OutIcacheRd, OutFetchValid} !== {even, even}) begin
                errors++; $display("FAIL stream_flags c=%0d got rd=%b v=%b exp rd=%b v=%b", c, OutIcacheRd, OutFetchValid, even, even);
            end
            if (even) begin
                checks++; if (OutIcachePc !== e_req) begin errors++; $display("FAIL stream_req_pc c=%0d got %h exp %h", c, OutIcachePc, e_req); end
                checks++;
                if ({OutFetchPc, OutFetchInstr} !== {e_out, 32'h13}) begin
                    errors++; $display("FAIL stream_word c=%0d got pc=%h i=%h exp pc=%h i=00000013", c, OutFetchPc, OutFetchInstr, e_out);
                end
            end
        end
    endtask

    task automatic test_stall();
        hash_mode = 0; resp_lat = 1; accept_pct = 100;
        do_reset();
        for (int c = 1; c <= 9; c++) begin
            @(posedge InClk); #1;
            InFetchAccept = (c >= 7);
            @(negedge InClk);
            if (c >= 2 && c <= 6) begin
                checks++;
                if ({OutFetchValid, OutFetchPc, OutFetchInstr, OutIcacheRd} !== {1'b1, BOOT, 32'h13, 1'b0}) begin
                    errors++; $display("FAIL stall_hold c=%0d got v=%b pc=%h i=%h rd=%b exp v=1 pc=%h i=13 rd=0",
                        c, OutFetchValid, OutFetchPc, OutFetchInstr, OutIcacheRd, BOOT);
                end
            end
            if (c == 7) begin
                checks++;
                if ({OutIcacheRd, OutIcachePc, OutFetchValid} !== {1'b1, BOOT + 32'd4, 1'b1}) begin
                    errors++; $display("FAIL stall_release got rd=%b pc=%h v=%b exp rd=1 pc=%h v=1", OutIcacheRd, OutIcachePc, OutFetchValid, BOOT + 32'd4);
                end
            end
            if (c == 9) begin
                checks++;
                if ({OutFetchValid, OutFetchPc} !== {1'b1, BOOT + 32'd4}) begin
                    errors++; $display("FAIL stall_next got v=%b pc=%h exp v=1 pc=%h", OutFetchValid, OutFetchPc, BOOT + 32'd4);
                end
            end
        end
    endtask

    task automatic test_redirect_outstanding();
        hash_mode = 1; resp_lat = 3; accept_pct = 100;
        do_reset();
        for (int c = 1; c <= 8; c++) begin
            @(posedge InClk); #1;
            InBranchRequest = (c == 1);
            InBranchPc      = 32'h8000_0103;
            @(negedge InClk);
            checks++;
            if (OutSquashDecode !== (c == 1)) begin errors++; $display("FAIL redir_squash c=%0d got %b exp %b", c, OutSquashDecode, (c == 1)); end
            if (c <= 7) begin
                checks++;
                if (OutFetchValid !== 1'b0) begin errors++; $display("FAIL redir_late_word c=%0d got v=%b pc=%h exp v=0", c, OutFetchValid, OutFetchPc); end
                checks++;
                if (OutIcacheRd !== (c == 4)) begin errors++; $display("FAIL redir_rd c=%0d got %b exp %b", c, OutIcacheRd, (c == 4)); end
            end
            if (c == 4) begin
                checks++; if (OutIcachePc !== 32'h8000_0100) begin errors++; $display("FAIL redir_target got %h exp 80000100", OutIcachePc); end
            end
            if (c == 8) begin
                checks++;
                if ({OutFetchValid, OutFetchPc, OutFetchInstr} !== {1'b1, 32'h8000_0100, mem_word(32'h8000_0100)}) begin
                    errors++; $display("FAIL redir_first_word got v=%b pc=%h i=%h exp v=1 pc=80000100 i=%h",
                        OutFetchValid, OutFetchPc, OutFetchInstr, mem_word(32'h8000_0100));
                end
            end
        end
        InBranchRequest = 1'b0;
    endtask

    task automatic test_redirect_with_response();
        hash_mode = 1; resp_lat = 1; accept_pct = 100;
        do_reset();
        for (int c = 1; c <= 4; c++) begin
            @(posedge InClk); #1;
            InBranchRequest = (c == 1);
            InBranchPc      = 32'h8000_0300;
            @(negedge InClk);
            if (c == 1) begin
                checks++;
                if ({OutSquashDecode, OutIcacheRd, InIcacheValid} !== 3'b101) begin
                    errors++; $display("FAIL same_cycle_redir got sq=%b rd=%b icv=%b exp sq=1 rd=0 icv=1", OutSquashDecode, OutIcacheRd, InIcacheValid);
                end
            end
            if (c == 2) begin
                checks++;
                if ({OutFetchValid, OutIcacheRd, OutIcachePc} !== {1'b0, 1'b1, 32'h8000_0300}) begin
                    errors++; $display("FAIL same_cycle_after got v=%b rd=%b pc=%h exp v=0 rd=1 pc=80000300", OutFetchValid, OutIcacheRd, OutIcachePc);
                end
            end
            if (c == 4) begin
                checks++;
                if ({OutFetchValid, OutFetchPc} !== {1'b1, 32'h8000_0300}) begin
                    errors++; $display("FAIL same_cycle_word got v=%b pc=%h exp v=1 pc=80000300", OutFetchValid, OutFetchPc);
                end
            end
        end
        InBranchRequest = 1'b0;
    endtask

    task automatic test_page_fault();
        logic [31:0] tgt;
        tgt = 32'h8000_0200;
        hash_mode = 1; resp_lat = 1; accept_pct = 100;
        page_fault_pc = BOOT + 32'd4; err_fault_pc = tgt + 32'd4;
        do_reset();
        for (int c = 1; c <= 14; c++) begin
            @(posedge InClk); #1;
            InBranchRequest = (c == 8);
            InBranchPc      = tgt;
            @(negedge InClk);
            case (c)
                2: begin
                    checks++;
                    if ({OutFetchValid, OutFetchPc, OutFetchInstr} !== {1'b1, BOOT, mem_word(BOOT)}) begin
                        errors++; $display("FAIL fault_pre_word got v=%b pc=%h i=%h", OutFetchValid, OutFetchPc, OutFetchInstr);
                    end
                end
                4: begin
                    checks++;
                    if ({OutFetchValid, OutFetchPc, OutFetchInstr, OutFetchFaultPage, OutFetchFaultFetch, OutIcacheRd}
                        !== {1'b1, BOOT + 32'd4, 32'h0, 1'b1, 1'b0, 1'b0}) begin
                        errors++; $display("FAIL page_fault_word got v=%b pc=%h i=%h fp=%b ff=%b rd=%b exp v=1 pc=%h i=0 fp=1 ff=0 rd=0",
                            OutFetchValid, OutFetchPc, OutFetchInstr, OutFetchFaultPage, OutFetchFaultFetch, OutIcacheRd, BOOT + 32'd4);
                    end
                end
                5, 6, 7, 14: begin
                    checks++;
                    if ({OutIcacheRd, OutFetchValid} !== 2'b00) begin
                        errors++; $display("FAIL fault_halt c=%0d got rd=%b v=%b exp rd=0 v=0", c, OutIcacheRd, OutFetchValid);
                    end
                end
                8: begin
                    checks++;
                    if ({OutSquashDecode, OutIcacheRd} !== 2'b10) begin errors++; $display("FAIL fault_redir got sq=%b rd=%b exp sq=1 rd=0", OutSquashDecode, OutIcacheRd); end
                end
                9: begin
                    checks++;
                    if ({OutIcacheRd, OutIcachePc} !== {1'b1, tgt}) begin errors++; $display("FAIL fault_resume got rd=%b pc=%h exp rd=1 pc=%h", OutIcacheRd, OutIcachePc, tgt); end
                end
                11: begin
                    checks++;
                    if ({OutFetchValid, OutFetchPc, OutFetchInstr, OutFetchFaultPage, OutFetchFaultFetch} !== {1'b1, tgt, mem_word(tgt), 2'b00}) begin
                        errors++; $display("FAIL fault_resume_word got v=%b pc=%h i=%h fp=%b ff=%b", OutFetchValid, OutFetchPc, OutFetchInstr, OutFetchFaultPage, OutFetchFaultFetch);
                    end
                end
                13: begin
                    checks++;
                    if ({OutFetchValid, OutFetchPc, OutFetchInstr, OutFetchFaultPage, OutFetchFaultFetch, OutIcacheRd}
                        !== {1'b1, tgt + 32'd4, 32'h0, 1'b0, 1'b1, 1'b0}) begin
                        errors++; $display("FAIL bus_error_word got v=%b pc=%h i=%h fp=%b ff=%b rd=%b exp v=1 pc=%h i=0 fp=0 ff=1 rd=0",
                            OutFetchValid, OutFetchPc, OutFetchInstr, OutFetchFaultPage, OutFetchFaultFetch, OutIcacheRd, tgt + 32'd4);
                    end
                end
                default: ;
            endcase
        end
        InBranchRequest = 1'b0;
        page_fault_pc = 32'h1; err_fault_pc = 32'h1;
    endtask

    task automatic test_async_reset();
        hash_mode = 1; resp_lat = 1; accept_pct = 100;
        page_fault_pc = 32'h1; err_fault_pc = 32'h1;
        do_reset();
        @(posedge InClk); #1;
        @(posedge InClk); #1;
        @(negedge InClk);
        checks++;
        if ({OutFetchValid, OutFetchPc} !== {1'b1, BOOT}) begin errors++; $display("FAIL areset_pre got v=%b pc=%h exp v=1 pc=%h", OutFetchValid, OutFetchPc, BOOT); end
        @(posedge InClk); #3;
        InRst = 1'b1;
        #1;
        checks++;
        if ({OutIcacheRd, OutIcachePc} !== {1'b0, BOOT}) begin errors++; $display("FAIL areset_req got rd=%b pc=%h exp rd=0 pc=%h", OutIcacheRd, OutIcachePc, BOOT); end
        checks++;
        if ({OutFetchValid, OutFetchInstr, OutFetchPc, OutFetchFaultFetch, OutFetchFaultPage, OutSquashDecode} !== 68'h0) begin
            errors++; $display("FAIL areset_outs got v=%b i=%h pc=%h ff=%b fp=%b sq=%b exp all 0",
                OutFetchValid, OutFetchInstr, OutFetchPc, OutFetchFaultFetch, OutFetchFaultPage, OutSquashDecode);
        end
        accept_pct = 0;
        @(posedge InClk); #1;
        @(negedge InClk);
        stray_req = 1'b1;
        @(posedge InClk); #1;
        InRst = 1'b0;
        @(negedge InClk);
        checks++;
        if ({OutIcacheRd, OutIcachePc} !== {1'b1, BOOT}) begin errors++; $display("FAIL areset_restart got rd=%b pc=%h exp rd=1 pc=%h", OutIcacheRd, OutIcachePc, BOOT); end
        @(posedge InClk); #1;
        @(negedge InClk);
        checks++;
        if ({OutFetchValid, OutIcacheRd, OutIcachePc} !== {1'b0, 1'b1, BOOT}) begin
            errors++; $display("FAIL areset_stray got v=%b rd=%b pc=%h exp v=0 rd=1 pc=%h", OutFetchValid, OutIcacheRd, OutIcachePc, BOOT);
        end
        accept_pct = 100;
        for (int c = 0; c < 3; c++) begin
            @(posedge InClk); #1;
        end
        @(negedge InClk);
        checks++;
        if ({OutFetchValid, OutFetchPc, OutFetchInstr} !== {1'b1, BOOT, mem_word(BOOT)}) begin
            errors++; $display("FAIL areset_first_word got v=%b pc=%h i=%h exp v=1 pc=%h i=%h", OutFetchValid, OutFetchPc, OutFetchInstr, BOOT, mem_word(BOOT));
        end
    endtask

    // Random latency, acceptance, decode stalls and redirects. The model: the
    // request stream is sequential word addresses from the last redirect target,
    // and decode sees exactly the requested words in order, minus everything
    // in flight or buffered when a redirect hits.
    task automatic test_random();
        logic [31:0] exp_req_pc;
        logic [31:0] e;
        bit          br;
        int          delivered;
        hash_mode = 1; accept_pct = 70; resp_lat = 1;
        page_fault_pc = 32'h1; err_fault_pc = 32'h1;
        do_reset();
        exp_q.delete();
        exp_req_pc = BOOT;
        delivered  = 0;
        for (int c = 0; c < 600; c++) begin
            if (c > 0) begin
                @(posedge InClk); #1;
            end
            resp_lat        = $urandom_range(1, 4);
            InFetchAccept   = ($urandom_range(0, 3) != 0);
            br              = ($urandom_range(0, 24) == 0);
            InBranchRequest = br;
            InBranchPc      = 32'h8000_0000 | ($urandom & 32'h0000_FFFF);
            @(negedge InClk);
            checks++;
            if (OutSquashDecode !== br) begin errors++; $display("FAIL rand_squash c=%0d got %b exp %b", c, OutSquashDecode, br); end
            if (OutIcacheRd && InIcacheAccept) begin
                checks++;
                if (OutIcachePc !== exp_req_pc) begin errors++; $display("FAIL rand_req_pc c=%0d got %h exp %h", c, OutIcachePc, exp_req_pc); end
                exp_q.push_back(exp_req_pc);
                exp_req_pc = exp_req_pc + 32'd4;
            end
            if (OutFetchValid && InFetchAccept && !br) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rand_unexpected_word c=%0d got pc=%h exp no word", c, OutFetchPc);
                end else begin
                    e = exp_q.pop_front();
                    delivered++;
                    if ({OutFetchPc, OutFetchInstr, OutFetchFaultFetch, OutFetchFaultPage} !== {e, mem_word(e), 2'b00}) begin
                        errors++; $display("FAIL rand_word c=%0d got pc=%h i=%h ff=%b fp=%b exp pc=%h i=%h ff=0 fp=0",
                            c, OutFetchPc, OutFetchInstr, OutFetchFaultFetch, OutFetchFaultPage, e, mem_word(e));
                    end
                end
            end
            if (br) begin
                exp_q.delete();
                exp_req_pc = InBranchPc & ~32'h3;
            end
        end
        InBranchRequest = 1'b0;
        checks++;
        if (delivered < 20) begin errors++; $display("FAIL rand_progress got %0d words exp at least 20", delivered); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        InRst = 1'b1; InFetchAccept = 1'b0; InBranchRequest = 1'b0; InBranchPc = '0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_outstanding();
        test_redirect_with_response();
        test_page_fault();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
